// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data access) in front of a single-ported,
// fixed-latency memory. Data has priority with a starvation guard for fetch.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic             if_ack_o,
  output logic [31:0]      if_rdata_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_wdata_i,
  output logic             d_ack_o,
  output logic [31:0]      d_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic [1:0]       grant_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0]  GNT_NONE   = 2'b00;
  localparam logic [1:0]  GNT_IF     = 2'b01;
  localparam logic [1:0]  GNT_D      = 2'b10;
  localparam logic [3:0]  CNT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [3:0]       starve_r, starve_s;
  logic [1:0]       grant_r, grant_s;
  logic             we_r, we_s;
  logic [31:0]      addr_r, addr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic [31:0]      if_rdata_r, if_rdata_s;
  logic [31:0]      d_rdata_r, d_rdata_s;
  logic             if_ack_r, if_ack_s;
  logic             d_ack_r, d_ack_s;
  logic             mem_en_r, mem_en_s;
  logic             mem_we_r, mem_we_s;
  logic [31:0]      mem_addr_r, mem_addr_s;
  logic [31:0]      mem_wdata_r, mem_wdata_s;
  logic [CNT_W-1:0] conflict_r, conflict_s;
  logic             pick_if_s;
  logic             waiting_s;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    starve_s   = starve_r;
    grant_s    = grant_r;
    we_s       = we_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    if_rdata_s = if_rdata_r;
    d_rdata_s  = d_rdata_r;
    if_ack_s   = 1'b0;
    d_ack_s    = 1'b0;
    pick_if_s  = if_req_i & (~d_req_i | (starve_r == STARVE_LIM));

    case (state_r)
      ST_IDLE: begin
        if (start_i && (if_req_i || d_req_i)) begin
          state_s = ST_ACC;
          cnt_s   = CNT_INIT;
          if (pick_if_s) begin
            grant_s  = GNT_IF;
            we_s     = 1'b0;
            addr_s   = if_addr_i;
            wdata_s  = 32'd0;
            starve_s = 4'd0;
          end else begin
            grant_s = GNT_D;
            we_s    = d_we_i;
            addr_s  = d_addr_i;
            wdata_s = d_wdata_i;
            // Only data grants that bypass a waiting fetch count toward starvation.
            if (if_req_i) begin
              if (starve_r != STARVE_LIM) begin
                starve_s = starve_r + 4'd1;
              end else begin
                starve_s = starve_r;
              end
            end else begin
              starve_s = 4'd0;
            end
          end
        end else begin
          state_s = ST_IDLE;
          grant_s = GNT_NONE;
        end
      end
      ST_ACC: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
          if (grant_r == GNT_IF) begin
            if_rdata_s = mem_rdata_i;
            if_ack_s   = 1'b1;
          end else begin
            d_ack_s = 1'b1;
            if (!we_r) begin
              d_rdata_s = mem_rdata_i;
            end else begin
              d_rdata_s = d_rdata_r;
            end
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        grant_s = GNT_NONE;
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = GNT_NONE;
      end
    endcase

    mem_en_s    = (state_s == ST_ACC);
    mem_we_s    = (state_s == ST_ACC) & we_s;
    mem_addr_s  = (state_s == ST_ACC) ? (addr_s & ADDR_MASK) : 32'd0;
    mem_wdata_s = (state_s == ST_ACC) ? wdata_s : 32'd0;
  end

  // Conflict cycles: the memory is busy and the other requester is waiting.
  always_comb begin
    conflict_s = conflict_r;
    waiting_s  = ((grant_r == GNT_IF) && d_req_i) || ((grant_r == GNT_D) && if_req_i);
    if ((state_r != ST_IDLE) && waiting_s && (conflict_r != CNT_MAX)) begin
      conflict_s = conflict_r + CNT_ONE;
    end else begin
      conflict_s = conflict_r;
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      starve_r    <= 4'd0;
      grant_r     <= GNT_NONE;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      if_rdata_r  <= 32'd0;
      d_rdata_r   <= 32'd0;
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      conflict_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      starve_r    <= starve_s;
      grant_r     <= grant_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      if_rdata_r  <= if_rdata_s;
      d_rdata_r   <= d_rdata_s;
      if_ack_r    <= if_ack_s;
      d_ack_r     <= d_ack_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      conflict_r  <= conflict_s;
    end
  end

  assign if_ack_o       = if_ack_r;
  assign if_rdata_o     = if_rdata_r;
  assign d_ack_o        = d_ack_r;
  assign d_rdata_o      = d_rdata_r;
  assign mem_en_o       = mem_en_r;
  assign mem_we_o       = mem_we_r;
  assign mem_addr_o     = mem_addr_r;
  assign mem_wdata_o    = mem_wdata_r;
  assign grant_o        = grant_r;
  assign conflict_cnt_o = conflict_r;
  assign stall_o        = (if_req_i & ~if_ack_r) | (d_req_i & ~d_ack_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios,
// MEM_LAT=1 instance for the short-latency / address-alignment case.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  grant;
  logic [15:0] conflict_cnt;

  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_stall;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_grant;
  logic [15:0] b_conflict_cnt;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .grant_o(grant), .stall_o(stall), .conflict_cnt_o(conflict_cnt)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4), .CNT_W(16)) dut_lat1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_rdata_o(b_if_rdata),
    .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
    .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(b_mem_rdata), .grant_o(b_grant), .stall_o(b_stall), .conflict_cnt_o(b_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0;
    d_wdata = 32'd0; mem_rdata = 32'd0;
    b_if_req = 1'b0; b_if_addr = 32'd0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'd0;
    b_d_wdata = 32'd0; b_mem_rdata = 32'd0;

    #3;
    check_val("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_val("rst_grant", {30'd0, grant}, 32'd0);
    check_val("rst_if_rdata", if_rdata, 32'd0);
    check_val("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    check_val("rst_b_d_rdata", b_d_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch only
    if_req = 1'b1; if_addr = 32'h8; mem_rdata = 32'h2008_0005;
    tick();
    check_val("f_en1", {31'd0, mem_en}, 32'd1);
    check_val("f_addr", mem_addr, 32'h8);
    check_val("f_grant", {30'd0, grant}, 32'd1);
    check_val("f_stall_busy", {31'd0, stall}, 32'd1);
    tick();
    check_val("f_en2", {31'd0, mem_en}, 32'd1);
    check_val("f_ack_early", {31'd0, if_ack}, 32'd0);
    tick();
    check_val("f_en_off", {31'd0, mem_en}, 32'd0);
    check_val("f_ack", {31'd0, if_ack}, 32'd1);
    check_val("f_rdata", if_rdata, 32'h2008_0005);
    check_val("f_stall_ack", {31'd0, stall}, 32'd0);
    if_req = 1'b0;
    tick();
    check_val("f_ack_pulse", {31'd0, if_ack}, 32'd0);
    check_val("f_rdata_hold", if_rdata, 32'h2008_0005);
    tick();
    check_val("f_no_regrant", {31'd0, mem_en}, 32'd0);

    // Simultaneous requests: data write wins, fetch follows after the bubble
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h5;
    tick();
    check_val("s_grant_d", {30'd0, grant}, 32'd2);
    check_val("s_we", {31'd0, mem_we}, 32'd1);
    check_val("s_wdata", mem_wdata, 32'h5);
    check_val("s_addr", mem_addr, 32'h4);
    tick();
    tick();
    check_val("s_d_ack", {31'd0, d_ack}, 32'd1);
    check_val("s_if_ack_not", {31'd0, if_ack}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_val("s_bubble", {31'd0, mem_en}, 32'd0);
    check_val("s_stall_wait", {31'd0, stall}, 32'd1);
    check_val("s_wr_keeps_rdata", d_rdata, 32'd0);
    tick();
    check_val("s_grant_if", {30'd0, grant}, 32'd1);
    check_val("s_if_addr", mem_addr, 32'h10);
    check_val("s_if_we", {31'd0, mem_we}, 32'd0);
    tick();
    tick();
    check_val("s_if_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    tick();
    check_val("s_conflict", {16'd0, conflict_cnt}, 32'd3);

    // Starvation guard: four data grants, then fetch, then data again
    mem_rdata = 32'hCAFE_0001;
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("st_grant%0d", i), {30'd0, grant}, (i == 4) ? 32'd1 : 32'd2);
      if (i < 5) repeat (4) tick();
    end
    check_val("st_d_rdata", d_rdata, 32'hCAFE_0001);
    tick();
    tick();
    check_val("st_last_ack", {31'd0, d_ack}, 32'd1);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    check_val("st_idle", {31'd0, mem_en}, 32'd0);

    // Asynchronous reset in the middle of an access
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    check_val("r_en_before", {31'd0, mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("r_en_cleared", {31'd0, mem_en}, 32'd0);
    check_val("r_grant_cleared", {30'd0, grant}, 32'd0);
    check_val("r_if_rdata_cleared", if_rdata, 32'd0);
    check_val("r_d_rdata_cleared", d_rdata, 32'd0);
    check_val("r_conflict_cleared", {16'd0, conflict_cnt}, 32'd0);
    if_req = 1'b0;
    tick();
    tick();
    check_val("r_no_ack", {31'd0, if_ack}, 32'd0);
    rst_n = 1'b1;
    if_req = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    check_val("r_fresh_en", {31'd0, mem_en}, 32'd1);
    tick();
    tick();
    check_val("r_fresh_ack", {31'd0, if_ack}, 32'd1);
    check_val("r_fresh_rdata", if_rdata, 32'h1111_2222);
    if_req = 1'b0;
    tick();

    // Run enable low holds off grants
    start = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; mem_rdata = 32'h0000_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("e_no_en%0d", i), {31'd0, mem_en}, 32'd0);
      check_val($sformatf("e_stall%0d", i), {31'd0, stall}, 32'd1);
    end
    start = 1'b1;
    tick();
    check_val("e_grant", {30'd0, grant}, 32'd2);
    check_val("e_en", {31'd0, mem_en}, 32'd1);
    tick();
    tick();
    check_val("e_ack", {31'd0, d_ack}, 32'd1);
    check_val("e_rdata", d_rdata, 32'h0000_BEEF);
    d_req = 1'b0;
    tick();

    // MEM_LAT=1: unaligned data read
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h7; b_mem_rdata = 32'h0BAD_F00D;
    tick();
    check_val("l1_en", {31'd0, b_mem_en}, 32'd1);
    check_val("l1_addr", b_mem_addr, 32'h4);
    tick();
    check_val("l1_en_off", {31'd0, b_mem_en}, 32'd0);
    check_val("l1_ack", {31'd0, b_d_ack}, 32'd1);
    check_val("l1_rdata", b_d_rdata, 32'h0BAD_F00D);
    b_d_req = 1'b0;
    tick();
    check_val("l1_ack_pulse", {31'd0, b_d_ack}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
